// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, command/response codes and the
// frame parity helper used by the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_BAT     = 8'hAA;

  // Width of the frame timeout counter (750_000 cycles at 50 MHz fits in 20 bits)
  localparam int PS2_TMO_W = 20;

  // PS/2 uses odd parity: the parity bit makes the count of ones in data+parity odd
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions one raw PS/2 pad level: two-flop synchroniser, then a run-length
// filter that accepts a new level only after FILTER_LEN consecutive samples,
// plus a one-cycle pulse on each accepted 1->0 transition.
module ps2_line_sync #(
  parameter int FILTER_LEN = 8
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] run;

  // Two-flop synchroniser; the idle bus level is high
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], raw};
  end

  // Count consecutive samples that disagree with the accepted level; flip on the FILTER_LEN-th
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      run   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync[1] == level) begin
        run <= '0;
      end else if (run == RUN_LAST) begin
        run   <= '0;
        level <= sync[1];
        fall  <= level;
      end else begin
        run <= run + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus clock, issues a
// request-to-send, then shifts one command byte out on the device-generated
// clock, checks the device ack and reports done or error. Lines are only ever
// pulled low through the *_oe outputs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15,
  parameter int FILTER_LEN = 8
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_INHIBIT   = INHIBIT;
  localparam logic [2:0] S_REQ       = REQ;
  localparam logic [2:0] S_SHIFT     = SHIFT;
  localparam logic [2:0] S_ACK       = ACK;
  localparam logic [2:0] S_WAIT_IDLE = WAIT_IDLE;

  localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam logic [PS2_TMO_W-1:0] INHIBIT_LOAD = PS2_TMO_W'(INHIBIT_CYC);
  // Expiry is detected on the cycle the counter is already zero, so load one less
  // to put tx_err exactly TIMEOUT_CYC cycles after the clock is released.
  localparam logic [PS2_TMO_W-1:0] TIMEOUT_LOAD = PS2_TMO_W'(TIMEOUT_CYC - 1);

  logic [2:0]           state;
  logic [PS2_TMO_W-1:0] cnt;
  logic [9:0]           shreg;
  logic [3:0]           bitcnt;
  logic                 ok;
  logic                 clk_lvl;
  logic                 clk_fall;
  logic                 dat_lvl;
  logic                 dat_fall_unused;
  logic                 accept;
  logic                 timed;
  logic                 expired;
  logic                 shift_en;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .raw     (ps2_clk_i),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .raw     (ps2_dat_i),
    .level   (dat_lvl),
    .fall    (dat_fall_unused)
  );

  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = tx_ready & tx_valid;
  assign timed    = (state == S_SHIFT) | (state == S_ACK) | (state == S_WAIT_IDLE);
  assign expired  = timed & (cnt == '0);
  assign shift_en = (state == S_SHIFT) & ~expired & clk_fall;

  // Frame shift register {stop, parity, data}: loaded at accept, shifted LSB-first on each fall
  always_ff @(posedge sys_clk) begin
    if (accept)        shreg <= {1'b1, odd_parity(tx_data), tx_data};
    else if (shift_en) shreg <= {1'b0, shreg[9:1]};
  end

  // Transmit sequencer: inhibit, request-to-send, bit shifting, ack check, return to idle
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      ok         <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      if (expired) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx_err     <= 1'b1;
        state      <= S_IDLE;
      end else begin
        if (timed) cnt <= cnt - PS2_TMO_W'(1);
        case (state)
          S_IDLE: begin
            if (tx_valid) begin
              bitcnt     <= '0;
              ok         <= 1'b0;
              cnt        <= INHIBIT_LOAD;
              ps2_clk_oe <= 1'b1;
              state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (cnt == '0) begin
              ps2_dat_oe <= 1'b1;
              state      <= S_REQ;
            end else begin
              cnt <= cnt - PS2_TMO_W'(1);
            end
          end
          S_REQ: begin
            ps2_clk_oe <= 1'b0;
            cnt        <= TIMEOUT_LOAD;
            state      <= S_SHIFT;
          end
          S_SHIFT: begin
            if (shift_en) begin
              ps2_dat_oe <= ~shreg[0];
              bitcnt     <= bitcnt + 4'd1;
              if (bitcnt == 4'd9) state <= S_ACK;
            end
          end
          S_ACK: begin
            if (clk_fall) begin
              ok    <= ~dat_lvl;
              state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (clk_lvl && dat_lvl) begin
              tx_done <= ok;
              tx_err  <= ~ok;
              state   <= S_IDLE;
            end
          end
          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
